subneg_loader: RTL and testbench
================================

SUBNEG_LOADER -- requirements
Module: subneg_loader

Interface
REQ-001 Parameter MEM_DEPTH, default 22: number of 7-bit program-memory words the loader can fill.
REQ-002 Parameter ADDR_W, default 5: memory address width.
REQ-003 Parameter DATA_W, default 7: memory word width.
REQ-004 Parameter HEADER, default 8'hA5: frame start byte.
REQ-005 Parameter TIMEOUT, default 255: maximum idle cycles between bytes inside a frame.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 ld_valid  input  1  byte offered on ld_data this cycle.
REQ-009 ld_data  input  8  frame byte.
REQ-010 ld_ready  output  1  loader accepts a byte this cycle; a transfer occurs when ld_valid && ld_ready.
REQ-011 mem_we  output  1  one-cycle write strobe to the program memory of the subneg CPU.
REQ-012 mem_addr  output  ADDR_W  write address, valid with mem_we.
REQ-013 mem_wdata  output  DATA_W  write data, valid with mem_we.
REQ-014 cpu_run  output  1  high = CPU may execute; low = CPU held in reset.
REQ-015 load_err  output  1  last frame rejected.
REQ-016 load_count  output  ADDR_W  number of data words written in the current/last frame.

Function
REQ-017 Frame format SHALL be HEADER, LEN (1..MEM_DEPTH), LEN data bytes, CSUM, where CSUM equals the 8-bit modulo-256 sum of the data bytes.
REQ-018 States SHALL be IDLE, LEN, DATA, CSUM, DONE, ERR.
REQ-019 IDLE: HEADER -> LEN; any other byte is discarded with no state change.
REQ-020 LEN: value 0 or >MEM_DEPTH -> ERR; otherwise latch LEN, clear load_count and checksum, then -> DATA.
REQ-021 DATA: each byte with bit 7 clear SHALL drive mem_we=1, mem_addr=load_count, and mem_wdata=ld_data[6:0] on the following cycle; the byte SHALL be added to the checksum and load_count incremented.
REQ-022 DATA: a byte with bit 7 set -> ERR with no write.
REQ-023 DATA -> CSUM after the LEN-th byte is accepted.
REQ-024 CSUM: match -> DONE; mismatch -> ERR.
REQ-025 ld_ready SHALL be low during the cycle in which mem_we is high, and high in all other cycles after reset (one-cycle backpressure per data word).
REQ-026 cpu_run SHALL be high only in DONE, asserting the cycle after the CSUM byte is accepted.
REQ-027 load_err SHALL be high only in ERR.
REQ-028 DONE or ERR: a HEADER byte -> LEN, dropping cpu_run or load_err on the next cycle; other bytes are ignored.
REQ-029 In LEN, DATA, and CSUM, TIMEOUT consecutive cycles without a transfer -> ERR.
REQ-030 A transfer in the same cycle the timeout would expire SHALL win: the byte is accepted and the timer cleared.
REQ-031 The timer SHALL be cleared on every transfer and held at zero in IDLE, DONE, and ERR.
REQ-032 Memory words written before an error SHALL NOT be rolled back; cpu_run remains low until a full valid frame completes.
REQ-033 mem_addr SHALL never exceed MEM_DEPTH-1.

Reset
REQ-034 While reset is high at a clock edge: state=IDLE, ld_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, load_err=0, load_count=0, timer=0, checksum=0.
REQ-035 ld_ready SHALL rise the first cycle after reset deasserts.
REQ-036 Reset mid-frame SHALL abandon the frame; any pending write strobe is dropped.

Structure
REQ-037 Package subneg_pkg SHALL hold the loader state enum, HEADER, MEM_DEPTH, ADDR_W, and DATA_W, shared with the CPU core.
REQ-038 One sub-module, subneg_byte_timer (clear/enable/expire inter-byte counter), SHALL be instantiated; everything else lives in subneg_loader.

Verification
REQ-039 Frame A5,03,12,12,03,27 -> three mem_we pulses (addr0=18, addr1=18, addr2=3), ld_ready low on each pulse cycle, cpu_run=1 one cycle after the last byte, load_count=3.
REQ-040 Frame A5,02,05,06,0C -> load_err=1, cpu_run=0; both words still written.
REQ-041 A5,17 (LEN 23) -> ERR, no mem_we pulse; A5,00 -> ERR.
REQ-042 A5,02,05 followed by 255 idle cycles -> ERR; a repeat where the byte arrives on cycle 255 -> accepted, no error.
REQ-043 From DONE, send A5 -> cpu_run=0 next cycle; reset asserted mid-DATA -> all outputs zero, IDLE, a later valid frame completes.

Source files
------------

// File: rtl/subneg_pkg.sv
// Shared definitions for the subneg CPU and its program loader.
// The loader state enum and memory geometry live here so the core and loader agree.
package subneg_pkg;

    localparam int unsigned MEM_DEPTH = 22;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 7;
    localparam logic [7:0]  HEADER    = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCsum,
        StDone,
        StErr
    } loader_state_e;

endpackage

// File: rtl/subneg_byte_timer.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// flags the cycle in which the TIMEOUT-th idle cycle is reached.
module subneg_byte_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             at_limit;

    assign at_limit = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign expire   = enable && at_limit;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable && !at_limit) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/subneg_loader.sv
// Byte-stream program loader for the subneg CPU: parses HEADER/LEN/data/CSUM
// frames, writes program memory and releases the CPU only after a valid frame.
module subneg_loader
    import subneg_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = subneg_pkg::MEM_DEPTH,
    parameter int unsigned ADDR_W    = subneg_pkg::ADDR_W,
    parameter int unsigned DATA_W    = subneg_pkg::DATA_W,
    parameter logic [7:0]  HEADER    = subneg_pkg::HEADER,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_run,
    output logic              load_err,
    output logic [ADDR_W-1:0] load_count
);

    localparam logic [7:0] MAX_LEN = 8'(MEM_DEPTH);

    loader_state_e     state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [7:0]        csum_q, csum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;

    logic xfer;
    logic tmr_expire;
    logic active_q;
    logic active_d;

    assign xfer     = ld_valid && ready_q;
    assign active_q = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
    assign active_d = (state_d == StLen) || (state_d == StData) || (state_d == StCsum);

    // Cleared on any transfer and whenever the frame is not in progress next cycle.
    subneg_byte_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (xfer || !active_d),
        .enable (active_q),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ready_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (xfer && ld_data == HEADER) begin
                    state_d = StLen;
                end
            end
            StLen: begin
                if (xfer) begin
                    if (ld_data == 8'd0 || ld_data > MAX_LEN) begin
                        state_d = StErr;
                    end else begin
                        len_d   = ld_data;
                        count_d = '0;
                        csum_d  = '0;
                        state_d = StData;
                    end
                end else if (tmr_expire) begin
                    state_d = StErr;
                end
            end
            StData: begin
                if (xfer) begin
                    if (ld_data[7]) begin
                        state_d = StErr;
                    end else begin
                        // Write lands next cycle; stall the source for that cycle.
                        we_d    = 1'b1;
                        ready_d = 1'b0;
                        addr_d  = count_q;
                        wdata_d = ld_data[DATA_W-1:0];
                        csum_d  = csum_q + ld_data;
                        count_d = count_q + 1'b1;
                        if (8'(count_q) + 8'd1 == len_q) begin
                            state_d = StCsum;
                        end
                    end
                end else if (tmr_expire) begin
                    state_d = StErr;
                end
            end
            StCsum: begin
                if (xfer) begin
                    state_d = (ld_data == csum_q) ? StDone : StErr;
                end else if (tmr_expire) begin
                    state_d = StErr;
                end
            end
            StDone, StErr: begin
                if (xfer && ld_data == HEADER) begin
                    state_d = StLen;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            count_q <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
        end
    end

    assign ld_ready   = ready_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_run    = (state_q == StDone);
    assign load_err   = (state_q == StErr);
    assign load_count = count_q;

endmodule

// File: tb/tb_subneg_loader.sv
// Directed-frame bench for subneg_loader; expected memory writes go through a
// scoreboard queue checked by an independent monitor on the falling edge.
module tb_subneg_loader;

    logic       clk;
    logic       reset;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [6:0] mem_wdata;
    logic       cpu_run;
    logic       load_err;
    logic [4:0] load_count;

    typedef struct packed {
        logic [4:0] addr;
        logic [6:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    subneg_loader dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_run    (cpu_run),
        .load_err   (load_err),
        .load_count (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [6:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Holds the byte until accepted, returns #1 after the transfer edge.
    task automatic send(input logic [7:0] b);
        int n;
        n        = 0;
        ld_valid = 1'b1;
        ld_data  = b;
        while (!ld_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ld_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_stall: ld_ready stuck at 0, expected 1 (byte %0h)", b);
        end else begin
            @(posedge clk);
            #1;
        end
        ld_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            wr_t w;
            check("ready_low_on_we", {31'd0, ld_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0h, expected no write",
                         mem_addr, mem_wdata);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", {27'd0, mem_addr}, {27'd0, w.addr});
                check("wr_data", {25'd0, mem_wdata}, {25'd0, w.data});
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, ld_ready}, 32'd0);
        check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_addr"}, {27'd0, mem_addr}, 32'd0);
        check({tag, "_wdata"}, {25'd0, mem_wdata}, 32'd0);
        check({tag, "_run"}, {31'd0, cpu_run}, 32'd0);
        check({tag, "_err"}, {31'd0, load_err}, 32'd0);
        check({tag, "_count"}, {27'd0, load_count}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'd0, ld_ready}, 32'd1);

        // Non-header bytes in IDLE are discarded.
        send(8'h33);
        send(8'h12);
        check("idle_discard_run", {31'd0, cpu_run}, 32'd0);
        check("idle_discard_err", {31'd0, load_err}, 32'd0);

        // Good 3-word frame.
        push_wr(5'd0, 7'h12);
        push_wr(5'd1, 7'h12);
        push_wr(5'd2, 7'h03);
        send(8'hA5);
        send(8'h03);
        send(8'h12);
        send(8'h12);
        send(8'h03);
        check("pre_csum_run", {31'd0, cpu_run}, 32'd0);
        send(8'h27);
        check("good_run", {31'd0, cpu_run}, 32'd1);
        check("good_err", {31'd0, load_err}, 32'd0);
        check("good_count", {27'd0, load_count}, 32'd3);

        // HEADER from DONE drops cpu_run, then a bad-checksum frame.
        send(8'hA5);
        check("done_hdr_run", {31'd0, cpu_run}, 32'd0);
        push_wr(5'd0, 7'h05);
        push_wr(5'd1, 7'h06);
        send(8'h02);
        send(8'h05);
        send(8'h06);
        send(8'h0C);
        check("badsum_err", {31'd0, load_err}, 32'd1);
        check("badsum_run", {31'd0, cpu_run}, 32'd0);
        check("badsum_count", {27'd0, load_count}, 32'd2);

        // Out-of-range lengths.
        send(8'hA5);
        check("err_hdr_clears", {31'd0, load_err}, 32'd0);
        send(8'h17);
        check("len23_err", {31'd0, load_err}, 32'd1);
        send(8'hA5);
        send(8'h00);
        check("len0_err", {31'd0, load_err}, 32'd1);

        // Data byte with bit 7 set aborts without a write.
        send(8'hA5);
        send(8'h02);
        send(8'h85);
        check("bit7_err", {31'd0, load_err}, 32'd1);

        // Timeout expires after 255 idle cycles.
        push_wr(5'd0, 7'h05);
        send(8'hA5);
        send(8'h02);
        send(8'h05);
        repeat (254) @(posedge clk);
        #1;
        check("tmo_not_yet", {31'd0, load_err}, 32'd0);
        @(posedge clk);
        #1;
        check("tmo_err", {31'd0, load_err}, 32'd1);
        check("tmo_run", {31'd0, cpu_run}, 32'd0);

        // Byte arriving on the 255th idle cycle wins over the timeout.
        push_wr(5'd0, 7'h05);
        push_wr(5'd1, 7'h06);
        send(8'hA5);
        send(8'h02);
        send(8'h05);
        repeat (254) @(posedge clk);
        #1;
        send(8'h06);
        check("tmo_race_err", {31'd0, load_err}, 32'd0);
        send(8'h0B);
        check("tmo_race_run", {31'd0, cpu_run}, 32'd1);

        // Checksum wraps modulo 256: 7F*3 = 17D.
        push_wr(5'd0, 7'h7F);
        push_wr(5'd1, 7'h7F);
        push_wr(5'd2, 7'h7F);
        send(8'hA5);
        send(8'h03);
        send(8'h7F);
        send(8'h7F);
        send(8'h7F);
        send(8'h7D);
        check("wrap_run", {31'd0, cpu_run}, 32'd1);

        // Maximum length frame: 22 words of 01, checksum 16.
        send(8'hA5);
        send(8'd22);
        for (int i = 0; i < 22; i++) begin
            push_wr(5'(i), 7'h01);
            send(8'h01);
        end
        send(8'h16);
        check("max_run", {31'd0, cpu_run}, 32'd1);
        check("max_count", {27'd0, load_count}, 32'd22);

        // Reset in the same cycle a data byte is offered: write dropped.
        send(8'hA5);
        send(8'h03);
        ld_valid = 1'b1;
        ld_data  = 8'h12;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("midreset");
        reset    = 1'b0;
        ld_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_ready", {31'd0, ld_ready}, 32'd1);
        check("midreset_we", {31'd0, mem_we}, 32'd0);

        push_wr(5'd0, 7'h01);
        push_wr(5'd1, 7'h02);
        send(8'hA5);
        send(8'h02);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        check("post_reset_run", {31'd0, cpu_run}, 32'd1);
        check("post_reset_count", {27'd0, load_count}, 32'd2);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
